led_pio_arbiter: RTL and testbench
==================================

Name: led_pio_arbiter

Overview:
- Avalon-MM master that shares the 11-bit LED PIO slave between two requesters: game logic (port 0) and gesture status (port 1).
- Arbitrates with round-robin priority and issues single-cycle write transfers to the PIO data register.
- Applies a hold-off after each write so one requester cannot flicker the LEDs faster than the other can be seen.
- Sits between the snake game/gesture logic and the LED PIO in the system interconnect.

Parameters:
- DATA_W, 11, LED data width; matches the PIO data register.
- HOLD_CYCLES, 4, idle cycles enforced after each write before the next grant; 0 is legal.
- PIO_ADDR, 0, Avalon word address of the PIO data register.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  2  per-requester write request, level; held until matching ack
- req_data0  in  DATA_W  LED value from requester 0
- req_data1  in  DATA_W  LED value from requester 1
- ack  out  2  one-cycle pulse; the write for that requester has been issued
- pio_address  out  2  Avalon address to the PIO
- pio_chipselect  out  1  Avalon chipselect
- pio_write_n  out  1  Avalon write strobe, active low
- pio_writedata  out  DATA_W  Avalon write data
- pio_readdata  in  DATA_W  PIO read data; combinational, valid in the same cycle
- busy  out  1  high in any state other than IDLE
- last_grant  out  1  index of the most recently served requester
- readback_err  out  1  sticky mismatch flag; used only when LED_READBACK_EN is defined

Behaviour:
- Reset values:
  - state = IDLE; ack = 0; pio_chipselect = 0; pio_write_n = 1.
  - pio_address = PIO_ADDR; pio_writedata = 0; busy = 0; last_grant = 1, so requester 0 wins first; readback_err = 0.
- FSM states: IDLE, WRITE, CHECK (only when LED_READBACK_EN is defined), HOLD.
- IDLE:
  - If any req bit is high, grant one requester.
  - Latch the granted req_dataN into pio_writedata.
  - Go to WRITE on the next edge.
- Arbitration:
  - One requester high: that requester is granted.
  - Both high: the requester != last_grant is granted.
  - The grant is taken at the IDLE edge. A req that drops before that edge is ignored.
- WRITE (exactly 1 cycle):
  - Outputs: pio_chipselect = 1, pio_write_n = 0, pio_address = PIO_ADDR.
  - ack[grant] = 1 in this same cycle; last_grant updates at the end of the cycle.
  - Next state: CHECK if readback is enabled; else HOLD if HOLD_CYCLES > 0; else IDLE.
- HOLD:
  - Counter counts down from HOLD_CYCLES-1; chipselect = 0.
  - Go to IDLE when the counter reaches 0. Requests that arrive during HOLD wait.
  - Counter width is clog2(HOLD_CYCLES+1); HOLD_CYCLES = 0 bypasses HOLD entirely.
- Latency: req high in IDLE → write strobe 1 cycle later → ack in the same cycle as the strobe.
  - Steady-state minimum spacing between writes is 2 + HOLD_CYCLES cycles, plus 1 if CHECK is present.
- Requester obligation: a requester must drop req or change data in the cycle after its ack; otherwise it is re-served.
- Reset mid-operation: every output returns to its reset value on the next edge; an interrupted write is not retried.
- Bus outputs are registered. No write strobe is issued in any state other than WRITE.

Optional Feature:
- Macro: LED_READBACK_EN.
- Defined:
  - After WRITE, enter CHECK for 1 cycle with pio_chipselect = 1, pio_write_n = 1, pio_address = PIO_ADDR.
  - In CHECK, compare pio_readdata with the latched pio_writedata. On mismatch, set readback_err; it stays set until reset.
  - Then HOLD or IDLE as above.
- Undefined: no CHECK state; readback_err is tied to 0 and pio_readdata is unused.

Test Plan:
- Reset, then req = 2'b01 with req_data0 = 11'h2A5 → the next cycle shows chipselect = 1, write_n = 0, writedata = 11'h2A5, ack = 2'b01; busy returns to 0 after 4 HOLD cycles.
- Both req held high from reset, data0 = 11'h001, data1 = 11'h400 → the writes alternate 0,1,0,1, with strobes spaced 6 cycles apart (HOLD_CYCLES = 4, no readback).
- req[1] rises during HOLD of a requester-0 write → no strobe until HOLD ends, then requester 1 is served; ack[1] pulses exactly once.
- Assert reset in the WRITE cycle → the next edge shows chipselect = 0, write_n = 1, ack = 0, busy = 0, last_grant = 1.
- HOLD_CYCLES = 0, req[0] held high → a strobe every 2 cycles, and no HOLD state is entered.
- LED_READBACK_EN defined, bench model returns pio_readdata = writedata ^ 11'h001 during CHECK → readback_err = 1 after CHECK and stays 1 through later correct writes until reset.

Source files
------------

// File: rtl/led_pio_arbiter.sv
// Round-robin arbiter for the LED PIO: 1-cycle write strobe the cycle after a grant, then a HOLD_CYCLES hold-off.
// Requests wait (level, held until ack) while busy. LED_READBACK_EN adds a 1-cycle CHECK read after each write.
module led_pio_arbiter #(
  parameter int DATA_W      = 11,
  parameter int HOLD_CYCLES = 4,
  parameter int PIO_ADDR    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  output logic [1:0]        ack,
  output logic [1:0]        pio_address,
  output logic              pio_chipselect,
  output logic              pio_write_n,
  output logic [DATA_W-1:0] pio_writedata,
  input  logic [DATA_W-1:0] pio_readdata,
  output logic              busy,
  output logic              last_grant,
  output logic              readback_err
);

  localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
`ifdef LED_READBACK_EN
    CHECK = 2'd2,
`endif
    HOLD  = 2'd3
  } state_t;

  state_t            state, state_d;
  logic              grant, grant_d;
  logic              last_d;
  logic [CNT_W-1:0]  hold_cnt, cnt_d;
  logic [DATA_W-1:0] wdata_d;
  logic [1:0]        ack_d;
  logic              cs_d, wn_d;
`ifdef LED_READBACK_EN
  logic              err_q, err_d;
`endif

  assign pio_address = 2'(PIO_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      grant          <= 1'b0;
      last_grant     <= 1'b1;
      hold_cnt       <= '0;
      pio_writedata  <= '0;
      ack            <= 2'b00;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      busy           <= 1'b0;
    end else begin
      state          <= state_d;
      grant          <= grant_d;
      last_grant     <= last_d;
      hold_cnt       <= cnt_d;
      pio_writedata  <= wdata_d;
      ack            <= ack_d;
      pio_chipselect <= cs_d;
      pio_write_n    <= wn_d;
      busy           <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state;
    grant_d = grant;
    last_d  = last_grant;
    cnt_d   = hold_cnt;
    wdata_d = pio_writedata;
    ack_d   = 2'b00;
    cs_d    = 1'b0;
    wn_d    = 1'b1;
`ifdef LED_READBACK_EN
    err_d   = err_q;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          // Contention goes to whoever was not served last.
          grant_d = (req == 2'b11) ? ~last_grant : req[1];
          wdata_d = grant_d ? req_data1 : req_data0;
          ack_d   = grant_d ? 2'b10 : 2'b01;
          cs_d    = 1'b1;
          wn_d    = 1'b0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        last_d = grant;
`ifdef LED_READBACK_EN
        cs_d    = 1'b1;
        state_d = CHECK;
`else
        if (HOLD_CYCLES > 0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          state_d = IDLE;
        end
`endif
      end
`ifdef LED_READBACK_EN
      CHECK: begin
        if (pio_readdata != pio_writedata) err_d = 1'b1;
        if (HOLD_CYCLES > 0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      HOLD: begin
        if (hold_cnt == '0) state_d = IDLE;
        else cnt_d = hold_cnt - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LED_READBACK_EN
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign readback_err = err_q;
`else
  logic unused_readdata;
  assign unused_readdata = ^pio_readdata;
  assign readback_err    = 1'b0;
`endif

endmodule

// File: tb/tb_led_pio_arbiter.sv
// Scoreboarded bench for led_pio_arbiter: one instance with HOLD_CYCLES=4, one with HOLD_CYCLES=0.
module tb_led_pio_arbiter;

`ifdef LED_READBACK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  typedef struct packed {
    logic [1:0]  ack;
    logic [10:0] data;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        corrupt;
  logic [1:0]  req, req_b;
  logic [10:0] req_data0, req_data1, req_data0_b, req_data1_b;
  logic [1:0]  ack, ack_b, pio_address, pio_address_b;
  logic        pio_chipselect, pio_write_n, busy, last_grant, readback_err;
  logic        pio_chipselect_b, pio_write_n_b, busy_b, last_grant_b, readback_err_b;
  logic [10:0] pio_writedata, pio_readdata, pio_writedata_b, pio_readdata_b;

  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int   cyc = 0;
  int   n_checks = 0, n_pass = 0;
  int   ack1_cnt = 0, run1 = 0, a1;
  int   n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign pio_readdata   = (corrupt && pio_chipselect && pio_write_n) ? (pio_writedata ^ 11'h001) : pio_writedata;
  assign pio_readdata_b = pio_writedata_b;

  led_pio_arbiter #(.DATA_W(11), .HOLD_CYCLES(4), .PIO_ADDR(0)) dut0 (
    .clk(clk), .reset(reset), .req(req), .req_data0(req_data0), .req_data1(req_data1),
    .ack(ack), .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata), .pio_readdata(pio_readdata),
    .busy(busy), .last_grant(last_grant), .readback_err(readback_err)
  );

  led_pio_arbiter #(.DATA_W(11), .HOLD_CYCLES(0), .PIO_ADDR(0)) dut1 (
    .clk(clk), .reset(reset), .req(req_b), .req_data0(req_data0_b), .req_data1(req_data1_b),
    .ack(ack_b), .pio_address(pio_address_b), .pio_chipselect(pio_chipselect_b),
    .pio_write_n(pio_write_n_b), .pio_writedata(pio_writedata_b), .pio_readdata(pio_readdata_b),
    .busy(busy_b), .last_grant(last_grant_b), .readback_err(readback_err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((q0.size() + q1.size()) != 0 && k < 60) begin
      step();
      k++;
    end
    check("drain", q0.size() + q1.size(), 0);
  endtask

  // Scoreboard for the HOLD_CYCLES=4 instance.
  always @(negedge clk) begin
    if (pio_chipselect === 1'b1 && pio_write_n === 1'b0) begin
      if (q0.size() == 0) begin
        check("wr0_spurious", {31'b0, pio_chipselect}, 0);
      end else begin
        e0 = q0.pop_front();
        check("wr0_data", pio_writedata, e0.data);
        check("wr0_ack", ack, e0.ack);
        check("wr0_cycle", cyc, e0.cyc);
        check("wr0_addr", pio_address, 0);
      end
    end else if (ack !== 2'b00 && reset === 1'b0) begin
      check("ack0_without_wr", ack, 0);
    end
    if (ack[1] === 1'b1) ack1_cnt++;
  end

  // Scoreboard for the HOLD_CYCLES=0 instance.
  always @(negedge clk) begin
    if (pio_chipselect_b === 1'b1 && pio_write_n_b === 1'b0) begin
      if (q1.size() == 0) begin
        check("wr1_spurious", {31'b0, pio_chipselect_b}, 0);
      end else begin
        e1 = q1.pop_front();
        check("wr1_data", pio_writedata_b, e1.data);
        check("wr1_ack", ack_b, e1.ack);
        check("wr1_cycle", cyc, e1.cyc);
      end
    end
    if (busy_b === 1'b1) run1++;
    else run1 = 0;
    if (run1 > 1 + CHK) check("h0_busy_run", run1, 1 + CHK);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; corrupt = 1'b0;
    req = 2'b00; req_data0 = '0; req_data1 = '0;
    req_b = 2'b00; req_data0_b = '0; req_data1_b = '0;
    repeat (3) step();

    check("rst_cs", pio_chipselect, 0);
    check("rst_wn", pio_write_n, 1);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_last_grant", last_grant, 1);
    check("rst_wdata", pio_writedata, 0);
    check("rst_addr", pio_address, 0);
    check("rst_err", readback_err, 0);
    reset = 1'b0;
    step();

    // Single request from requester 0.
    n = cyc;
    req = 2'b01; req_data0 = 11'h2A5;
    q0.push_back('{2'b01, 11'h2A5, n + 1});
    step();
    req = 2'b00;
    repeat (4 + CHK) step();
    check("t1_busy_in_hold", busy, 1);
    step();
    check("t1_busy_idle", busy, 0);
    check("t1_last_grant", last_grant, 0);

    // Both requesting from reset: strict alternation.
    reset = 1'b1;
    req = 2'b11; req_data0 = 11'h001; req_data1 = 11'h400;
    step(); step();
    reset = 1'b0;
    n = cyc;
    for (int k = 0; k < 4; k++)
      q0.push_back('{(k % 2 == 0) ? 2'b01 : 2'b10, (k % 2 == 0) ? 11'h001 : 11'h400,
                     n + 1 + k * (6 + CHK)});
    repeat (3 * (6 + CHK) + 1) step();
    req = 2'b00;
    wait_drain();
    repeat (6 + CHK) step();
    check("t2_busy_idle", busy, 0);
    check("t2_last_grant", last_grant, 1);

    // Requester 1 arrives during the hold-off of a requester-0 write.
    n = cyc;
    req = 2'b01; req_data0 = 11'h155;
    q0.push_back('{2'b01, 11'h155, n + 1});
    step();
    req = 2'b00;
    step(); step();
    check("t3_busy_hold", busy, 1);
    a1 = ack1_cnt;
    req = 2'b10; req_data1 = 11'h0AA;
    q0.push_back('{2'b10, 11'h0AA, n + 7 + CHK});
    repeat (4 + CHK) step();
    req = 2'b00;
    repeat (8 + CHK) step();
    check("t3_ack1_pulses", ack1_cnt - a1, 1);
    check("t3_last_grant", last_grant, 1);

    // Reset asserted during the WRITE cycle.
    n = cyc;
    req = 2'b01; req_data0 = 11'h7FF;
    q0.push_back('{2'b01, 11'h7FF, n + 1});
    step();
    reset = 1'b1; req = 2'b00;
    step();
    check("t4_cs", pio_chipselect, 0);
    check("t4_wn", pio_write_n, 1);
    check("t4_ack", ack, 0);
    check("t4_busy", busy, 0);
    check("t4_last_grant", last_grant, 1);
    check("t4_wdata", pio_writedata, 0);
    reset = 1'b0;
    repeat (8) step();
    check("t4_no_retry", busy, 0);

    // HOLD_CYCLES = 0: back-to-back writes every 2 cycles.
    n = cyc;
    req_b = 2'b01; req_data0_b = 11'h3C3;
    for (int k = 0; k < 4; k++) q1.push_back('{2'b01, 11'h3C3, n + 1 + k * (2 + CHK)});
    repeat (3 * (2 + CHK) + 1) step();
    req_b = 2'b00;
    wait_drain();
    repeat (4) step();
    check("t5_busy_idle", busy_b, 0);
    check("t5_last_grant", last_grant_b, 0);

`ifdef LED_READBACK_EN
    // Readback mismatch is sticky until reset.
    n = cyc;
    corrupt = 1'b1;
    req = 2'b01; req_data0 = 11'h0F0;
    q0.push_back('{2'b01, 11'h0F0, n + 1});
    step();
    req = 2'b00;
    step(); step();
    check("t6_err_set", readback_err, 1);
    corrupt = 1'b0;
    repeat (6) step();
    n = cyc;
    req = 2'b01; req_data0 = 11'h0F1;
    q0.push_back('{2'b01, 11'h0F1, n + 1});
    step();
    req = 2'b00;
    repeat (8) step();
    check("t6_err_sticky", readback_err, 1);
    reset = 1'b1;
    step();
    check("t6_err_reset", readback_err, 0);
    reset = 1'b0;
    step();
`else
    check("t6_err_tied", readback_err, 0);
    check("t6_err_tied_b", readback_err_b, 0);
`endif

    wait_drain();
    check("q0_empty", q0.size(), 0);
    check("q1_empty", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
